// File: rtl/color_bbox_tracker_pkg.sv
// Shared types and helpers for the colour bounding-box tracker.
//   state_t   : frame FSM states
//   rgb_t     : 24-bit pixel / threshold payload, R in the MSBs
//   in_window : inclusive per-channel window test
package tracker_pkg;

  localparam int unsigned RGB_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // An inverted window (lo > hi) on any channel can never be satisfied.
  function automatic logic in_window(rgb_t px, rgb_t lo, rgb_t hi);
    return (px.r >= lo.r) && (px.r <= hi.r) &&
           (px.g >= lo.g) && (px.g <= hi.g) &&
           (px.b >= lo.b) && (px.b <= hi.b);
  endfunction

endpackage

// File: rtl/color_bbox_tracker_bbox_accum.sv
// Per-target bounding-box accumulator.
//   clk, reset            : clock, synchronous active-high reset
//   i_clear               : start a new frame (wins over i_update)
//   i_update, i_x, i_y    : fold one matched pixel into the box
//   o_found               : count >= MIN_PIXELS (0 treated as 1)
//   o_center_*, o_width, o_height : box geometry, zero when not found
//   o_count               : saturating matched-pixel count
module bbox_accum #(
  parameter int unsigned COORD_W    = 12,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_update,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  output logic               o_found,
  output logic [COORD_W-1:0] o_center_x,
  output logic [COORD_W-1:0] o_center_y,
  output logic [COORD_W-1:0] o_width,
  output logic [COORD_W-1:0] o_height,
  output logic [CNT_W-1:0]   o_count
);

  localparam logic [CNT_W-1:0] MIN_EFF = (MIN_PIXELS == 0) ? CNT_W'(1) : CNT_W'(MIN_PIXELS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [COORD_W-1:0] r_min_x, r_min_y, r_max_x, r_max_y;
  logic [CNT_W-1:0]   r_count;
  logic [COORD_W:0]   w_sum_x, w_sum_y;
  logic               w_found;

  // Box and count registers; min starts at all-ones so the first hit always wins.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_min_x <= '1;
      r_min_y <= '1;
      r_max_x <= '0;
      r_max_y <= '0;
      r_count <= '0;
    end else if (i_update) begin
      if (i_x < r_min_x) r_min_x <= i_x;
      if (i_y < r_min_y) r_min_y <= i_y;
      if (i_x > r_max_x) r_max_x <= i_x;
      if (i_y > r_max_y) r_max_y <= i_y;
      if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
    end
  end

  // Centre sums carry one extra bit so the halving cannot overflow.
  always_comb begin
    w_found    = (r_count >= MIN_EFF);
    w_sum_x    = {1'b0, r_min_x} + {1'b0, r_max_x};
    w_sum_y    = {1'b0, r_min_y} + {1'b0, r_max_y};
    o_found    = w_found;
    o_count    = r_count;
    o_center_x = '0;
    o_center_y = '0;
    o_width    = '0;
    o_height   = '0;
    if (w_found) begin
      o_center_x = COORD_W'(w_sum_x >> 1);
      o_center_y = COORD_W'(w_sum_y >> 1);
      o_width    = r_max_x - r_min_x + COORD_W'(1);
      o_height   = r_max_y - r_min_y + COORD_W'(1);
    end
  end

endmodule

// File: rtl/color_bbox_tracker.sv
// Per-frame RGB colour-window tracker with one bounding box per target.
//   clock_50, reset         : clock, synchronous active-high reset
//   in_valid/in_ready       : pixel handshake; in_pixel R[23:16] G[15:8] B[7:0]
//   in_sof                  : marks pixel (0,0) of a frame
//   thr_lo, thr_hi          : per-target inclusive RGB windows, 24 bits per target
//   out_valid               : one-cycle report strobe; report fields hold until next
//   out_found/center/width/height/count : per-target report, packed by target
//   sync_err                : one-cycle pulse when a short frame is abandoned
module color_bbox_tracker
  import tracker_pkg::*;
#(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned COORD_W     = 12,
  parameter int unsigned NUM_TARGETS = 2,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned MIN_PIXELS  = 16
) (
  input  logic                           clock_50,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [23:0]                    in_pixel,
  input  logic                           in_sof,
  input  logic [NUM_TARGETS*24-1:0]      thr_lo,
  input  logic [NUM_TARGETS*24-1:0]      thr_hi,
  output logic                           out_valid,
  output logic [NUM_TARGETS-1:0]         out_found,
  output logic [NUM_TARGETS*COORD_W-1:0] out_center_x,
  output logic [NUM_TARGETS*COORD_W-1:0] out_center_y,
  output logic [NUM_TARGETS*COORD_W-1:0] out_width,
  output logic [NUM_TARGETS*COORD_W-1:0] out_height,
  output logic [NUM_TARGETS*CNT_W-1:0]   out_count,
  output logic                           sync_err
);

  localparam int unsigned     NT     = NUM_TARGETS;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

  state_t                r_state, w_next;
  logic                  w_ready, w_load;
  logic                  w_accept, w_take, w_resync, w_last, w_clear;
  logic [COORD_W-1:0]    r_x, r_y, w_px_x, w_px_y;
  logic [NT*RGB_W-1:0]   r_thr_lo, r_thr_hi, w_lo, w_hi;
  logic [NT-1:0]         w_match;
  logic                  r_s1_valid;
  logic [COORD_W-1:0]    r_s1_x, r_s1_y;
  logic [NT-1:0]         r_s1_match;
  logic [NT-1:0]         w_found;
  logic [NT*COORD_W-1:0] w_cx, w_cy, w_w, w_h;
  logic [NT*CNT_W-1:0]   w_cnt;
  logic                  r_out_valid, r_sync_err;
  logic [NT-1:0]         r_found;
  logic [NT*COORD_W-1:0] r_cx, r_cy, r_w, r_h;
  logic [NT*CNT_W-1:0]   r_cnt;

  // Handshake qualifiers; an SOF pixel always lands at (0,0).
  always_comb begin
    w_accept = in_valid && w_ready;
    w_take   = w_accept && ((r_state == ACCUM) || in_sof);
    w_resync = w_accept && in_sof && (r_state == ACCUM) &&
               ((r_x != '0) || (r_y != '0));
    w_px_x   = in_sof ? '0 : r_x;
    w_px_y   = in_sof ? '0 : r_y;
    w_last   = (w_px_x == X_LAST) && (w_px_y == Y_LAST);
    w_clear  = w_load || (w_accept && in_sof);
  end

  // FSM state register.
  always_ff @(posedge clock_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_take) w_next = ACCUM;
      ACCUM:   if (w_take && w_last) w_next = FLUSH;
      FLUSH:   w_next = REPORT;
      REPORT:  w_next = ACCUM;
      default: w_next = IDLE;
    endcase
  end

  // FSM outputs; in_ready is held low while reset is asserted.
  always_comb begin
    w_ready = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      IDLE, ACCUM: w_ready = !reset;
      REPORT:      w_load  = 1'b1;
      default:     ;
    endcase
  end

  assign in_ready = w_ready;

  // Raster position of the next expected pixel.
  always_ff @(posedge clock_50) begin
    if (reset || w_load) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_take) begin
      if (w_px_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_px_y == Y_LAST) ? '0 : w_px_y + COORD_W'(1);
      end else begin
        r_x <= w_px_x + COORD_W'(1);
        r_y <= w_px_y;
      end
    end
  end

  // Threshold shadows, re-latched on every accepted SOF.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_thr_lo <= '0;
      r_thr_hi <= '0;
    end else if (w_accept && in_sof) begin
      r_thr_lo <= thr_lo;
      r_thr_hi <= thr_hi;
    end
  end

  // The SOF pixel is classified with the window being latched alongside it.
  always_comb begin
    w_lo    = in_sof ? thr_lo : r_thr_lo;
    w_hi    = in_sof ? thr_hi : r_thr_hi;
    w_match = '0;
    for (int unsigned t = 0; t < NT; t++) begin
      w_match[t] = in_window(rgb_t'(in_pixel), rgb_t'(w_lo[t*RGB_W +: RGB_W]),
                             rgb_t'(w_hi[t*RGB_W +: RGB_W]));
    end
  end

  // Stage 1: position and match bits of the accepted pixel.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_match <= '0;
    end else begin
      r_s1_valid <= w_take;
      if (w_take) begin
        r_s1_x     <= w_px_x;
        r_s1_y     <= w_px_y;
        r_s1_match <= w_match;
      end
    end
  end

  // Stage 2: per-target accumulators; a clear drops whatever stage 1 holds.
  for (genvar t = 0; t < NT; t++) begin : g_tgt
    bbox_accum #(
      .COORD_W   (COORD_W),
      .CNT_W     (CNT_W),
      .MIN_PIXELS(MIN_PIXELS)
    ) u_accum (
      .clk       (clock_50),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_update  (r_s1_valid && r_s1_match[t]),
      .i_x       (r_s1_x),
      .i_y       (r_s1_y),
      .o_found   (w_found[t]),
      .o_center_x(w_cx[t*COORD_W +: COORD_W]),
      .o_center_y(w_cy[t*COORD_W +: COORD_W]),
      .o_width   (w_w[t*COORD_W +: COORD_W]),
      .o_height  (w_h[t*COORD_W +: COORD_W]),
      .o_count   (w_cnt[t*CNT_W +: CNT_W])
    );
  end

  // Report registers and strobes.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      r_found     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= w_load;
      r_sync_err  <= w_resync;
      if (w_load) begin
        r_found <= w_found;
        r_cx    <= w_cx;
        r_cy    <= w_cy;
        r_w     <= w_w;
        r_h     <= w_h;
        r_cnt   <= w_cnt;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign sync_err     = r_sync_err;
  assign out_found    = r_found;
  assign out_center_x = r_cx;
  assign out_center_y = r_cy;
  assign out_width    = r_w;
  assign out_height   = r_h;
  assign out_count    = r_cnt;

endmodule

// File: tb/tb_color_bbox_tracker.sv
// Directed bench for color_bbox_tracker on an 8x4 frame with two targets.
module tb_color_bbox_tracker;

  localparam int unsigned W    = 8;
  localparam int unsigned H    = 4;
  localparam int unsigned NT   = 2;
  localparam int unsigned CW   = 12;
  localparam int unsigned KW   = 20;
  localparam int unsigned NPIX = W * H;

  localparam logic [23:0] BLK   = 24'h000000;
  localparam logic [23:0] GRN   = 24'h00C800;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] T0_LO = 24'h006400;
  localparam logic [23:0] T0_HI = 24'h32FF32;
  localparam logic [23:0] T1_LO = 24'hC80000;
  localparam logic [23:0] T1_HI = 24'hFFFFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [23:0]       in_pixel = '0;
  logic              in_sof = 1'b0;
  logic [NT*24-1:0]  thr_lo = {T1_LO, T0_LO};
  logic [NT*24-1:0]  thr_hi = {T1_HI, T0_HI};
  logic              out_valid;
  logic [NT-1:0]     out_found;
  logic [NT*CW-1:0]  out_center_x, out_center_y, out_width, out_height;
  logic [NT*KW-1:0]  out_count;
  logic              sync_err;

  color_bbox_tracker #(
    .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .NUM_TARGETS(NT), .CNT_W(KW), .MIN_PIXELS(2)
  ) dut (
    .clock_50(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_sof(in_sof), .thr_lo(thr_lo), .thr_hi(thr_hi),
    .out_valid(out_valid), .out_found(out_found), .out_center_x(out_center_x),
    .out_center_y(out_center_y), .out_width(out_width), .out_height(out_height),
    .out_count(out_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Cycle counter and negedge monitor for reports, sync errors and ready gaps.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NT-1:0]    rep_found [16];
  logic [NT*CW-1:0] rep_cx [16], rep_cy [16], rep_w [16], rep_h [16];
  logic [NT*KW-1:0] rep_cnt [16];
  int               rep_cyc [16];
  int               gaps [16];
  int n_rep = 0, n_sync = 0, n_gap = 0, run = 0;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (n_rep < 16) begin
        rep_found[n_rep] = out_found;
        rep_cx[n_rep]    = out_center_x;
        rep_cy[n_rep]    = out_center_y;
        rep_w[n_rep]     = out_width;
        rep_h[n_rep]     = out_height;
        rep_cnt[n_rep]   = out_count;
        rep_cyc[n_rep]   = cyc;
      end
      n_rep++;
    end
    if (sync_err === 1'b1) n_sync++;
    if (!reset) begin
      if (!in_ready) run++;
      else if (run > 0) begin
        if (n_gap < 16) gaps[n_gap] = run;
        n_gap++;
        run = 0;
      end
    end
  end

  logic [23:0] fr [NPIX];
  int last_acc = 0;

  task automatic clr();
    for (int i = 0; i < int'(NPIX); i++) fr[i] = BLK;
  endtask

  task automatic set_px(input int x, input int y, input logic [23:0] c);
    fr[y*W + x] = c;
  endtask

  // Present one pixel and hold it until it is accepted (bounded wait).
  task automatic push(input logic [23:0] px, input logic sof);
    int w = 0;
    in_valid = 1'b1;
    in_pixel = px;
    in_sof   = sof;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("rdy_wait", 64'(in_ready), 64'd1);
    else begin
      @(posedge clk); #1;
      last_acc = cyc;
    end
    in_sof = 1'b0;
  endtask

  task automatic send_range(input int a, input int b);
    for (int i = a; i <= b; i++) push(fr[i], (i == 0));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rep(input int i, input int t, input logic f, input int cx,
                           input int cy, input int w, input int h, input int cnt);
    check($sformatf("r%0d_t%0d_found", i, t), 64'(rep_found[i][t]), 64'(f));
    check($sformatf("r%0d_t%0d_cx", i, t), 64'(rep_cx[i][t*CW +: CW]), 64'(cx));
    check($sformatf("r%0d_t%0d_cy", i, t), 64'(rep_cy[i][t*CW +: CW]), 64'(cy));
    check($sformatf("r%0d_t%0d_w", i, t), 64'(rep_w[i][t*CW +: CW]), 64'(w));
    check($sformatf("r%0d_t%0d_h", i, t), 64'(rep_h[i][t*CW +: CW]), 64'(h));
    check($sformatf("r%0d_t%0d_cnt", i, t), 64'(rep_cnt[i][t*KW +: KW]), 64'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int acc_a, acc_b;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_found", 64'(out_found), 64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Non-SOF pixels in IDLE are consumed and dropped.
    repeat (3) push(RED, 1'b0);

    // Frame A: three green pixels; Frame B back-to-back with in_valid held.
    clr(); set_px(2, 1, GRN); set_px(5, 1, GRN); set_px(3, 3, GRN);
    send_range(0, NPIX - 1);
    acc_a = last_acc;
    clr(); set_px(7, 3, GRN); set_px(0, 0, RED); set_px(7, 0, RED);
    send_range(0, NPIX - 1);
    acc_b = last_acc;
    idle(6);
    check("n_rep_ab", 64'(n_rep), 64'd2);
    check_rep(0, 0, 1'b1, 3, 2, 4, 3, 3);
    check_rep(0, 1, 1'b0, 0, 0, 0, 0, 0);
    check_rep(1, 0, 1'b0, 0, 0, 0, 0, 1);
    check_rep(1, 1, 1'b1, 3, 0, 8, 1, 2);
    check("lat_a", 64'(rep_cyc[0] - acc_a), 64'd2);
    check("lat_b", 64'(rep_cyc[1] - acc_b), 64'd2);
    check("gap_a", 64'(gaps[0]), 64'd2);
    check("gap_b", 64'(gaps[1]), 64'd2);
    check("n_sync_0", 64'(n_sync), 64'd0);

    // Short frame: SOF arrives at (4,2); the red pixel just before it is discarded.
    clr(); set_px(5, 0, RED); set_px(3, 2, RED);
    send_range(0, 19);
    clr(); set_px(1, 1, GRN); set_px(6, 2, GRN);
    send_range(0, NPIX - 1);
    idle(6);
    check("n_sync_1", 64'(n_sync), 64'd1);
    check("n_rep_d", 64'(n_rep), 64'd3);
    check_rep(2, 0, 1'b1, 3, 1, 6, 2, 2);
    check_rep(2, 1, 1'b0, 0, 0, 0, 0, 0);

    // Target 1 window switched to green mid-frame: applies from the next frame.
    clr(); set_px(3, 0, GRN); set_px(1, 3, GRN);
    send_range(0, 10);
    thr_lo[47:24] = T0_LO;
    thr_hi[47:24] = T0_HI;
    send_range(11, NPIX - 1);
    send_range(0, NPIX - 1);
    idle(6);
    check("n_rep_ef", 64'(n_rep), 64'd5);
    check_rep(3, 0, 1'b1, 2, 1, 3, 4, 2);
    check_rep(3, 1, 1'b0, 0, 0, 0, 0, 0);
    check_rep(4, 0, 1'b1, 2, 1, 3, 4, 2);
    check_rep(4, 1, 1'b1, 2, 1, 3, 4, 2);

    // Reset at (3,2) of a partial frame, then one clean frame.
    thr_lo[47:24] = T1_LO;
    thr_hi[47:24] = T1_HI;
    clr(); set_px(2, 0, GRN); set_px(1, 2, RED); set_px(2, 2, GRN);
    send_range(0, 18);
    in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_count", 64'(out_count), 64'd0);
    reset = 1'b0;
    clr(); set_px(4, 1, GRN); set_px(0, 1, RED); set_px(7, 1, RED);
    send_range(0, NPIX - 1);
    idle(6);
    check("n_rep_h", 64'(n_rep), 64'd6);
    check_rep(5, 0, 1'b0, 0, 0, 0, 0, 1);
    check_rep(5, 1, 1'b1, 3, 1, 8, 1, 2);
    check("n_gap", 64'(n_gap), 64'd6);
    check("hold_valid", 64'(out_valid), 64'd0);
    check("hold_cnt1", 64'(out_count[KW +: KW]), 64'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/color_bbox_tracker.md
Name: color_bbox_tracker

Overview:
- Per-frame RGB colour-window tracker; successor of the single-colour green tracker; sits downstream of the pixel FIFO, upstream of the overlay/HDMI stage.
- Classifies each streamed pixel against NUM_TARGETS runtime colour windows and keeps a true min/max bounding box and pixel count per target.
- Once per frame, emits a one-cycle report per target: centre, size, count and found flag.
- Frame sync is explicit (in_sof) rather than implied by a free-running counter.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- COORD_W, 12, coordinate/size width; must satisfy 2^COORD_W > max(WIDTH, HEIGHT).
- NUM_TARGETS, 2, number of independent colour windows.
- CNT_W, 20, per-target pixel-count width; saturating.
- MIN_PIXELS, 16, minimum count for found; a value of 0 is treated as 1.

Ports:
- clock_50  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accept; transfer occurs when in_valid & in_ready.
- in_pixel  in  24  R[23:16], G[15:8], B[7:0].
- in_sof  in  1  qualifies in_pixel as pixel (0,0) of a frame.
- thr_lo  in  NUM_TARGETS*24  per-target inclusive lower RGB bounds; target t at [24t+23:24t].
- thr_hi  in  NUM_TARGETS*24  per-target inclusive upper RGB bounds, same packing.
- out_valid  out  1  one-cycle report strobe.
- out_found  out  NUM_TARGETS  count >= MIN_PIXELS.
- out_center_x, out_center_y  out  NUM_TARGETS*COORD_W  box centre.
- out_width, out_height  out  NUM_TARGETS*COORD_W  box size.
- out_count  out  NUM_TARGETS*CNT_W  matched pixels.
- sync_err  out  1  one-cycle pulse on frame resync.

Behaviour:
- Reset: all outputs 0, in_ready 0 during reset, state IDLE, accumulators cleared, coordinates (0,0).
- States:
  - IDLE: in_ready=1; non-SOF pixels are consumed and dropped. An accepted SOF pixel enters ACCUM as pixel (0,0).
  - ACCUM: in_ready=1. Each accepted pixel advances x. At x=WIDTH-1, x wraps to 0 and y increments. Acceptance of pixel (WIDTH-1, HEIGHT-1) goes to FLUSH.
  - FLUSH: in_ready=0, one cycle, then REPORT.
  - REPORT: in_ready=0, one cycle. Output registers load, out_valid=1 the following cycle, accumulators clear, coordinates return to (0,0), then ACCUM.
- Thresholds: thr_lo/thr_hi are shadow-registered on every SOF acceptance. Mid-frame changes take effect next frame.
- Match: target t matches when lo <= channel <= hi for each of R, G and B. If lo > hi on any channel, that target never matches.
- Pipeline:
  - Stage 1 registers the pixel, x, y and per-target match bits.
  - Stage 2 updates min_x/min_y/max_x/max_y and count. min initialises to all-ones, max to 0; count saturates at 2^CNT_W-1.
- Latency: last pixel accepted at edge N gives out_valid high after edge N+2 for exactly one cycle. Two-cycle in_ready gap per frame.
- Report per target:
  - found=1: center = (min+max)>>1 computed in COORD_W+1 bits; width = max_x-min_x+1; height = max_y-min_y+1.
  - found=0: center, width and height are 0; out_count still reports the raw count.
  - Outputs hold until the next report.
- SOF in ACCUM at coordinate other than (0,0) (short frame):
  - Accumulators and the pipeline stage discarded, no report.
  - sync_err pulses, thresholds re-latched.
  - The SOF pixel becomes (0,0) of a new frame.
- SOF exactly at expected (0,0) is normal. Missing SOF at (0,0) is tolerated: counting continues.
- Reset mid-frame: everything discarded; returns to IDLE next cycle; no out_valid.
- in_valid with in_ready=0 is not consumed; the source holds data.

Decomposition:
- Package tracker_pkg holds:
  - state enum {IDLE, ACCUM, FLUSH, REPORT}.
  - rgb_t packed struct.
  - function in_window(rgb_t px, rgb_t lo, rgb_t hi).
- Sub-module bbox_accum, instantiated NUM_TARGETS times via generate, holds:
  - min/max/count registers;
  - clear and update inputs;
  - combinational centre/size/found outputs.

Test Plan:
- Bench config: WIDTH=8, HEIGHT=4, NUM_TARGETS=2, MIN_PIXELS=2, target0 window G>=100, R,B<=50; target1 R>=200.
- Green pixels at (2,1), (5,1), (3,3), SOF at (0,0), rest black -> out_valid once:
  - target0: found=1, min(2,1), max(5,3), center (3,2), width 4, height 3, count 3.
  - target1: found=0, all fields 0.
- Single green pixel at (7,3) -> target0 count 1, found=0, center/width/height 0.
- Back-to-back frames with in_valid held high -> in_ready low exactly 2 cycles after each last pixel; out_valid 2 cycles after the last accept; no pixel lost.
- SOF reasserted at (4,2) of frame 1 -> sync_err pulse, no out_valid for frame 1; next full frame reports normally.
- Thresholds changed mid-frame -> current frame uses old window, next frame uses new.
- Reset asserted at pixel (3,2), then a full frame -> no report from the partial frame; subsequent report matches that frame only.
